// File: rtl/mem_access_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : mem_access_ctrl_if
//  Description : Pipeline request/response and data-memory bus bundle for
//                the MEM-stage access controller.
//  Revision    : 1.0  initial release
// ============================================================================
interface mem_access_ctrl_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  req_valid;
    logic                  req_is_store;
    logic [2:0]            req_type;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [31:0]           req_wdata;
    logic                  stall;
    logic                  resp_valid;
    logic [31:0]           resp_rdata;
    logic                  exc_misalign;
    logic                  exc_timeout;
    logic                  mem_req;
    logic                  mem_we;
    logic [3:0]            mem_be;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [31:0]           mem_wdata;
    logic                  mem_ready;
    logic [31:0]           mem_rdata;

    // master: pipeline + memory environment; slave: the controller itself
    modport master (
        output req_valid, req_is_store, req_type, req_addr, req_wdata,
        output mem_ready, mem_rdata,
        input  stall, resp_valid, resp_rdata, exc_misalign, exc_timeout,
        input  mem_req, mem_we, mem_be, mem_addr, mem_wdata
    );

    modport slave (
        input  req_valid, req_is_store, req_type, req_addr, req_wdata,
        input  mem_ready, mem_rdata,
        output stall, resp_valid, resp_rdata, exc_misalign, exc_timeout,
        output mem_req, mem_we, mem_be, mem_addr, mem_wdata
    );
endinterface
`default_nettype wire

// File: rtl/mem_access_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mem_access_ctrl
//  Description : MEM-stage load/store sequencer for a single-port data memory
//                with wait states, byte lanes, load extension and timeout.
//  Revision    : 1.0  initial release
// ============================================================================
module mem_access_ctrl #(
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  wire logic         clk,
    input  wire logic         rst,
    mem_access_ctrl_if.slave  bus
);
    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_REQ  = 2'd1;
    localparam logic [1:0] c_ST_RESP = 2'd2;
    localparam logic [1:0] c_ST_TERR = 2'd3;

    localparam logic [2:0] c_T_B  = 3'd0;
    localparam logic [2:0] c_T_BU = 3'd1;
    localparam logic [2:0] c_T_H  = 3'd2;
    localparam logic [2:0] c_T_HU = 3'd3;
    localparam logic [2:0] c_T_W  = 3'd4;

    localparam logic [7:0] c_TIMEOUT = 8'(TIMEOUT_CYCLES);

    logic [1:0]            r_state, w_state_nxt;
    logic [7:0]            r_cnt;
    logic [7:0]            w_cnt_inc;
    logic                  r_is_store;
    logic [2:0]            r_type;
    logic [1:0]            r_lane;
    logic [31:0]           r_word;
    logic                  r_mem_req, r_mem_we;
    logic [3:0]            r_mem_be;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [31:0]           r_mem_wdata;
    logic                  w_legal, w_accept, w_timeout;
    logic [3:0]            w_be;
    logic [31:0]           w_wdata;
    logic [7:0]            w_byte;
    logic [15:0]           w_half;
    logic [31:0]           w_load;
    logic                  w_stall, w_resp_valid, w_exc_misalign, w_exc_timeout;
    logic [31:0]           w_resp_rdata;

    always_comb begin
        w_legal = 1'b0;
        case (bus.req_type)
            c_T_B, c_T_BU: w_legal = 1'b1;
            c_T_H, c_T_HU: w_legal = ~bus.req_addr[0];
            c_T_W:         w_legal = (bus.req_addr[1:0] == 2'b00);
            default:       w_legal = 1'b0;
        endcase
    end

    assign w_accept  = (r_state == c_ST_IDLE) & bus.req_valid & w_legal;
    assign w_cnt_inc = r_cnt + 8'd1;
    // The incremented count is compared so the abort lands after exactly TIMEOUT_CYCLES REQ cycles
    assign w_timeout = (r_state == c_ST_REQ) & ~bus.mem_ready &
                       (c_TIMEOUT != 8'd0) & (w_cnt_inc == c_TIMEOUT);

    // Store lane steering; stores treat BU as B and HU as H
    always_comb begin
        w_be    = 4'b1111;
        w_wdata = bus.req_is_store ? bus.req_wdata : 32'd0;
        if (bus.req_is_store) begin
            case (bus.req_type)
                c_T_B, c_T_BU: begin
                    w_be    = 4'b0001 << bus.req_addr[1:0];
                    w_wdata = {4{bus.req_wdata[7:0]}};
                end
                c_T_H, c_T_HU: begin
                    w_be    = bus.req_addr[1] ? 4'b1100 : 4'b0011;
                    w_wdata = {2{bus.req_wdata[15:0]}};
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: if (w_accept) w_state_nxt = c_ST_REQ;
            c_ST_REQ: begin
                if (bus.mem_ready)  w_state_nxt = c_ST_RESP;
                else if (w_timeout) w_state_nxt = c_ST_TERR;
            end
            default:   w_state_nxt = c_ST_IDLE;
        endcase
    end

    always_comb begin
        w_byte = r_word[{r_lane, 3'b000} +: 8];
        w_half = r_lane[1] ? r_word[31:16] : r_word[15:0];
        case (r_type)
            c_T_B:   w_load = {{24{w_byte[7]}}, w_byte};
            c_T_BU:  w_load = {24'd0, w_byte};
            c_T_H:   w_load = {{16{w_half[15]}}, w_half};
            c_T_HU:  w_load = {16'd0, w_half};
            default: w_load = r_word;
        endcase
    end

    always_comb begin
        w_stall        = 1'b0;
        w_resp_valid   = 1'b0;
        w_exc_misalign = 1'b0;
        w_exc_timeout  = 1'b0;
        w_resp_rdata   = 32'd0;
        case (r_state)
            c_ST_IDLE: begin
                w_stall        = w_accept;
                w_exc_misalign = bus.req_valid & ~w_legal;
            end
            c_ST_REQ:  w_stall = 1'b1;
            c_ST_RESP: begin
                w_resp_valid = 1'b1;
                w_resp_rdata = r_is_store ? 32'd0 : w_load;
            end
            default:   w_exc_timeout = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt       <= '0;
            r_is_store  <= 1'b0;
            r_type      <= '0;
            r_lane      <= '0;
            r_word      <= '0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_be    <= '0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_accept) begin
                        r_cnt       <= '0;
                        r_is_store  <= bus.req_is_store;
                        r_type      <= bus.req_type;
                        r_lane      <= bus.req_addr[1:0];
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= bus.req_is_store;
                        r_mem_be    <= w_be;
                        r_mem_addr  <= {bus.req_addr[ADDR_WIDTH-1:2], 2'b00};
                        r_mem_wdata <= w_wdata;
                    end
                end
                c_ST_REQ: begin
                    r_cnt <= w_cnt_inc;
                    if (bus.mem_ready) r_word <= bus.mem_rdata;
                    if (bus.mem_ready | w_timeout) begin
                        r_mem_req   <= 1'b0;
                        r_mem_we    <= 1'b0;
                        r_mem_be    <= '0;
                        r_mem_addr  <= '0;
                        r_mem_wdata <= '0;
                    end
                end
                default: r_cnt <= '0;
            endcase
        end
    end

    assign bus.stall        = w_stall;
    assign bus.resp_valid   = w_resp_valid;
    assign bus.resp_rdata   = w_resp_rdata;
    assign bus.exc_misalign = w_exc_misalign;
    assign bus.exc_timeout  = w_exc_timeout;
    assign bus.mem_req      = r_mem_req;
    assign bus.mem_we       = r_mem_we;
    assign bus.mem_be       = r_mem_be;
    assign bus.mem_addr     = r_mem_addr;
    assign bus.mem_wdata    = r_mem_wdata;
endmodule
`default_nettype wire
